cube_accum_drain: RTL and testbench

CUBE_ACCUM_DRAIN -- requirements
Module: cube_accum_drain

---
 rtl/cube_accum_drain.sv | 182 ++++++++++++++++++
 tb/tb_cube_accum_drain.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cube_accum_drain.sv
// cube_accum_drain
//   Accumulates a stream of SIZE x SIZE cube results into wide signed
//   accumulators. It then drains the tile row by row through a valid/ready
//   handshake, and saturates each element to OUT_WID on the way out.
//
// Ports
//   clock        rising-edge clock
//   rst          asynchronous active-high reset
//   start        begin a job (accepted only in IDLE)
//   cfg_k_tiles  cube results per job, sampled on an accepted start (0 acts as 1)
//   in_valid     acc_in carries a cube result (no backpressure)
//   acc_in       lane (i,j) at [(i*SIZE+j)*IN_WID +: IN_WID], signed
//   out_valid    out_data holds a drained row
//   out_ready    consumer accepts the row
//   out_row      index of the row on out_data
//   out_data     element j at [j*OUT_WID +: OUT_WID], saturated
//   out_last     out_valid on the final row
//   done         one-cycle pulse after the final row handshake
//   busy         not IDLE
//   drop_err     sticky: an input arrived outside ACCUM
module cube_accum_drain #(
    parameter int SIZE    = 8,
    parameter int IN_WID  = 35,
    parameter int ACC_WID = 48,
    parameter int OUT_WID = 32
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        start,
    input  logic [11:0]                 cfg_k_tiles,
    input  logic                        in_valid,
    input  logic [SIZE*SIZE*IN_WID-1:0] acc_in,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [2:0]                  out_row,
    output logic [SIZE*OUT_WID-1:0]     out_data,
    output logic                        out_last,
    output logic                        done,
    output logic                        busy,
    output logic                        drop_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        DRAIN
    } state_t;

    state_t state, state_next;

    logic [11:0]               k_reg;
    logic [11:0]               tile_cnt;
    logic [2:0]                row;
    logic signed [ACC_WID-1:0] acc [SIZE*SIZE];
    logic                      done_q;
    logic                      drop_q;

    logic accept_start;
    logic accum_en;
    logic row_adv;
    logic drain_end;

    // State register
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state and control strobes
    always_comb begin
        state_next   = state;
        accept_start = 1'b0;
        accum_en     = 1'b0;
        row_adv      = 1'b0;
        drain_end    = 1'b0;
        out_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_next   = ACCUM;
                end
            end
            ACCUM: begin
                if (in_valid) begin
                    accum_en = 1'b1;
                    if (tile_cnt == k_reg - 12'd1) begin
                        state_next = DRAIN;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    if (row == 3'(SIZE - 1)) begin
                        drain_end  = 1'b1;
                        state_next = IDLE;
                    end else begin
                        row_adv = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: job configuration, counters, accumulators and flags
    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            k_reg    <= 12'd1;
            tile_cnt <= '0;
            row      <= '0;
            done_q   <= 1'b0;
            drop_q   <= 1'b0;
            for (int unsigned n = 0; n < SIZE * SIZE; n++) begin
                acc[n] <= '0;
            end
        end else begin
            done_q <= drain_end;

            // A drop in the same cycle as an accepted start must still be flagged
            if (in_valid && state != ACCUM) begin
                drop_q <= 1'b1;
            end else if (accept_start) begin
                drop_q <= 1'b0;
            end

            if (accept_start) begin
                k_reg    <= (cfg_k_tiles == 12'd0) ? 12'd1 : cfg_k_tiles;
                tile_cnt <= '0;
            end else if (accum_en) begin
                tile_cnt <= tile_cnt + 12'd1;
            end

            if (accum_en && state_next == DRAIN) begin
                row <= '0;
            end else if (row_adv) begin
                row <= row + 3'd1;
            end

            for (int unsigned n = 0; n < SIZE * SIZE; n++) begin
                if (accept_start) begin
                    acc[n] <= '0;
                end else if (accum_en) begin
                    acc[n] <= acc[n] + ACC_WID'($signed(acc_in[n*IN_WID +: IN_WID]));
                end
            end
        end
    end

    // Saturate the selected row. A value fits when every bit from the top
    // down to the OUT_WID sign position matches.
    logic signed [ACC_WID-1:0] lane_val;
    logic [ACC_WID-OUT_WID:0]  hi_bits;

    always_comb begin
        out_data = '0;
        lane_val = '0;
        hi_bits  = '0;
        for (int unsigned j = 0; j < SIZE; j++) begin
            lane_val = acc[row * SIZE + j];
            hi_bits  = lane_val[ACC_WID-1:OUT_WID-1];
            if (hi_bits == '0 || hi_bits == '1) begin
                out_data[j*OUT_WID +: OUT_WID] = lane_val[OUT_WID-1:0];
            end else if (lane_val[ACC_WID-1]) begin
                out_data[j*OUT_WID +: OUT_WID] = {1'b1, {(OUT_WID-1){1'b0}}};
            end else begin
                out_data[j*OUT_WID +: OUT_WID] = {1'b0, {(OUT_WID-1){1'b1}}};
            end
        end
    end

    assign out_row  = row;
    assign out_last = out_valid && (row == 3'(SIZE - 1));
    assign done     = done_q;
    assign busy     = (state != IDLE);
    assign drop_err = drop_q;

endmodule

// File: tb/tb_cube_accum_drain.sv
// Scoreboard testbench for cube_accum_drain.
module tb_cube_accum_drain;

    localparam int SIZE    = 8;
    localparam int IN_WID  = 35;
    localparam int ACC_WID = 48;
    localparam int OUT_WID = 32;
    localparam int VW      = SIZE * SIZE * IN_WID;
    localparam int DW      = SIZE * OUT_WID;

    logic          clock = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [11:0]   cfg_k_tiles = '0;
    logic          in_valid = 1'b0;
    logic [VW-1:0] acc_in = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [2:0]    out_row;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          done;
    logic          busy;
    logic          drop_err;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [2:0]    row;
        logic [DW-1:0] data;
    } exp_t;

    exp_t exp_q[$];
    logic signed [ACC_WID-1:0] model_acc [SIZE*SIZE];

    cube_accum_drain #(
        .SIZE   (SIZE),
        .IN_WID (IN_WID),
        .ACC_WID(ACC_WID),
        .OUT_WID(OUT_WID)
    ) dut (
        .clock      (clock),
        .rst        (rst),
        .start      (start),
        .cfg_k_tiles(cfg_k_tiles),
        .in_valid   (in_valid),
        .acc_in     (acc_in),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_row    (out_row),
        .out_data   (out_data),
        .out_last   (out_last),
        .done       (done),
        .busy       (busy),
        .drop_err   (drop_err)
    );

    always #5 clock = ~clock;

    task automatic cycle();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [VW-1:0] vec_const(input longint c);
        logic [VW-1:0] v;
        logic [IN_WID-1:0] l;
        l = c[IN_WID-1:0];
        for (int n = 0; n < SIZE * SIZE; n++) v[n*IN_WID +: IN_WID] = l;
        return v;
    endfunction

    function automatic logic [VW-1:0] vec_index();
        logic [VW-1:0] v;
        for (int n = 0; n < SIZE * SIZE; n++) v[n*IN_WID +: IN_WID] = IN_WID'(n);
        return v;
    endfunction

    function automatic logic [VW-1:0] vec_rand();
        logic [VW-1:0] v;
        for (int n = 0; n < SIZE * SIZE; n++)
            v[n*IN_WID +: IN_WID] = {$urandom, $urandom};
        return v;
    endfunction

    function automatic logic [OUT_WID-1:0] sat(input logic signed [ACC_WID-1:0] a);
        longint v;
        v = a;
        if (v > 64'sd2147483647) return 32'h7FFF_FFFF;
        if (v < -64'sd2147483648) return 32'h8000_0000;
        return a[OUT_WID-1:0];
    endfunction

    task automatic push_expected();
        exp_t e;
        for (int i = 0; i < SIZE; i++) begin
            e.row = 3'(i);
            for (int j = 0; j < SIZE; j++)
                e.data[j*OUT_WID +: OUT_WID] = sat(model_acc[i*SIZE + j]);
            exp_q.push_back(e);
        end
    endtask

    task automatic start_job(input logic [11:0] k);
        for (int n = 0; n < SIZE * SIZE; n++) model_acc[n] = '0;
        start       = 1'b1;
        cfg_k_tiles = k;
        cycle();
        start = 1'b0;
        n_tests++;
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_busy: got %b want 1", busy);
        end
    endtask

    task automatic send_input(input logic [VW-1:0] v, input bit last);
        logic [IN_WID-1:0] l;
        for (int n = 0; n < SIZE * SIZE; n++) begin
            l = v[n*IN_WID +: IN_WID];
            model_acc[n] = model_acc[n] + {{(ACC_WID-IN_WID){l[IN_WID-1]}}, l};
        end
        if (last) push_expected();
        in_valid = 1'b1;
        acc_in   = v;
        cycle();
        in_valid = 1'b0;
    endtask

    // mode 0: out_ready held high; mode 1: random out_ready.
    // inject: drive a stray in_valid on the first drain cycle.
    task automatic drain(input int mode, input bit inject);
        int         rows = 0;
        int         cyc = 0;
        bit         stalled = 0;
        bit         rdy;
        logic [2:0] prow = '0;
        logic [DW-1:0] pdata = '0;
        exp_t       e;
        n_tests++;
        if (out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL first_valid_latency: out_valid=%b want 1", out_valid);
        end
        while (rows < SIZE && cyc < 400) begin
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL done_early: done=%b want 0 at row %0d", done, out_row);
            end
            if (inject && cyc == 0) begin
                in_valid = 1'b1;
                acc_in   = vec_rand();
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid) begin
                if (stalled) begin
                    n_tests++;
                    if (out_row !== prow || out_data !== pdata) begin
                        n_fail++;
                        $display("FAIL stall_stable: row %0d want %0d data %h want %h",
                                 out_row, prow, out_data, pdata);
                    end
                end
                rdy = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
                out_ready = rdy;
                if (rdy) begin
                    n_tests++;
                    if (out_last !== (rows == SIZE - 1)) begin
                        n_fail++;
                        $display("FAIL out_last: got %b on row %0d", out_last, out_row);
                    end
                    n_tests++;
                    if (exp_q.size() == 0) begin
                        n_fail++;
                        $display("FAIL scoreboard_empty: unexpected row %0d", out_row);
                    end else begin
                        e = exp_q.pop_front();
                        if (out_row !== e.row || out_data !== e.data) begin
                            n_fail++;
                            $display("FAIL row_data: row %0d want %0d data %h want %h",
                                     out_row, e.row, out_data, e.data);
                        end
                    end
                    rows++;
                    stalled = 0;
                end else begin
                    stalled = 1;
                    prow    = out_row;
                    pdata   = out_data;
                end
            end else begin
                out_ready = 1'b0;
            end
            cycle();
            cyc++;
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        n_tests++;
        if (rows != SIZE) begin
            n_fail++;
            $display("FAIL drain_timeout: got %0d rows want %0d", rows, SIZE);
        end
        if (mode == 0) begin
            n_tests++;
            if (cyc != SIZE) begin
                n_fail++;
                $display("FAIL drain_cycles: got %0d want %0d", cyc, SIZE);
            end
        end
        n_tests++;
        if (done !== 1'b1 || busy !== 1'b0 || out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL done_pulse: done=%b busy=%b out_valid=%b want 1,0,0",
                     done, busy, out_valid);
        end
        cycle();
        n_tests++;
        if (done !== 1'b0) begin
            n_fail++;
            $display("FAIL done_width: done=%b want 0", done);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) cycle();
        n_tests++;
        if ({out_valid, out_last, done, busy, drop_err} !== 5'b0 ||
            out_row !== 3'd0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL reset_state: v%b l%b d%b b%b e%b row %0d data %h want all 0",
                     out_valid, out_last, done, busy, drop_err, out_row, out_data);
        end
        rst = 1'b0;
    endtask

    task automatic test_k1();
        start_job(12'd1);
        send_input(vec_const(5), 1);
        drain(0, 0);
    endtask

    task automatic test_gap();
        start_job(12'd3);
        for (int t = 0; t < 3; t++) begin
            send_input(vec_index(), t == 2);
            if (t < 2) begin
                repeat (2) begin
                    n_tests++;
                    if (out_valid !== 1'b0) begin
                        n_fail++;
                        $display("FAIL early_valid: out_valid=%b want 0 after input %0d",
                                 out_valid, t);
                    end
                    cycle();
                end
            end
        end
        drain(0, 0);
    endtask

    task automatic test_saturate();
        start_job(12'd2);
        send_input(vec_const(64'sd17179869183), 0);
        send_input(vec_const(64'sd17179869183), 1);
        drain(0, 0);
        start_job(12'd2);
        send_input(vec_const(-64'sd17179869184), 0);
        send_input(vec_const(-64'sd17179869184), 1);
        drain(0, 0);
    endtask

    task automatic test_backpressure();
        start_job(12'd2);
        send_input(vec_rand(), 0);
        send_input(vec_rand(), 1);
        drain(1, 0);
    endtask

    task automatic test_drop();
        start_job(12'd2);
        send_input(vec_const(11), 0);
        start       = 1'b1;
        cfg_k_tiles = 12'd1;
        cycle();
        start = 1'b0;
        n_tests++;
        if (drop_err !== 1'b0 || out_valid !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_in_accum: drop_err=%b out_valid=%b busy=%b want 0,0,1",
                     drop_err, out_valid, busy);
        end
        send_input(vec_const(-4), 1);
        drain(0, 1);
        n_tests++;
        if (drop_err !== 1'b1) begin
            n_fail++;
            $display("FAIL drop_in_drain: drop_err=%b want 1", drop_err);
        end
        in_valid = 1'b1;
        acc_in   = vec_rand();
        cycle();
        in_valid = 1'b0;
        n_tests++;
        if (drop_err !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_in_idle: drop_err=%b busy=%b want 1,0", drop_err, busy);
        end
        start_job(12'd1);
        n_tests++;
        if (drop_err !== 1'b0) begin
            n_fail++;
            $display("FAIL drop_clear: drop_err=%b want 0", drop_err);
        end
        send_input(vec_const(21), 1);
        drain(0, 0);
        // start and a stray input together in IDLE: job starts, input is lost
        for (int n = 0; n < SIZE * SIZE; n++) model_acc[n] = '0;
        start       = 1'b1;
        cfg_k_tiles = 12'd1;
        in_valid    = 1'b1;
        acc_in      = vec_const(100);
        cycle();
        start    = 1'b0;
        in_valid = 1'b0;
        n_tests++;
        if (drop_err !== 1'b1 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL start_with_input: drop_err=%b busy=%b want 1,1", drop_err, busy);
        end
        send_input(vec_const(7), 1);
        drain(0, 0);
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bit   hit = 0;
        start_job(12'd1);
        send_input(vec_const(-3), 1);
        out_ready = 1'b1;
        for (int c = 0; c < 20 && !hit; c++) begin
            if (out_valid && out_row == 3'd3) begin
                rst = 1'b1;
                hit = 1;
            end else begin
                if (out_valid && exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    n_tests++;
                    if (out_row !== e.row || out_data !== e.data) begin
                        n_fail++;
                        $display("FAIL pre_abort_row: row %0d want %0d data %h want %h",
                                 out_row, e.row, out_data, e.data);
                    end
                end
                cycle();
            end
        end
        out_ready = 1'b0;
        #1;
        n_tests++;
        if (!hit || {out_valid, out_last, done, busy, drop_err} !== 5'b0 ||
            out_row !== 3'd0 || out_data !== '0) begin
            n_fail++;
            $display("FAIL abort_reset: reached=%0d v%b l%b d%b b%b e%b row %0d data %h want 0",
                     hit, out_valid, out_last, done, busy, drop_err, out_row, out_data);
        end
        exp_q.delete();
        repeat (3) begin
            cycle();
            n_tests++;
            if (done !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done: done=%b want 0", done);
            end
        end
        rst = 1'b0;
        start_job(12'd1);
        send_input(vec_const(9), 1);
        drain(0, 0);
    endtask

    initial begin
        test_reset();
        test_k1();
        test_gap();
        test_saturate();
        test_backpressure();
        test_drop();
        test_reset_mid();
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_leftover: %0d rows want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
